sobel: RTL and testbench

Row-streaming 3×3 Sobel edge detector for 256-pixel RGB scan lines. Each accepted row pushes into a two-row line buffer. The block then emits a full row of per-channel gradient magnitudes for the previous (centre) row. It sits after the median filter in the image-processing chain and feeds the row writer.

---
 rtl/sobel_pkg.sv | 15 +
 rtl/sobel_px.sv | 44 ++++
 rtl/sobel.sv | 50 +++++
 tb/tb_sobel.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared constants and packing helpers for the row-streaming Sobel edge detector.
// A row holds COLS pixels of CH channels; pixel 0 and channel R sit at the MSB end.
package sobel_pkg;
   localparam int COLS     = 256;
   localparam int PIX_W    = 8;
   localparam int CH       = 3;
   localparam int PIX_BITS = PIX_W * CH;
   localparam int ROW_W    = COLS * PIX_BITS;
   localparam int SAT_MAX  = 255;

   // MSB position of channel c (0 = R) of pixel j (0 = leftmost) within a row
   function automatic int bit_ofs(input int j, input int c);
      return ROW_W - 1 - PIX_BITS * j - PIX_W * c;
   endfunction
endpackage

// File: rtl/sobel_px.sv
// One-channel 3x3 Sobel kernel: |Gx| + |Gy| saturated to the channel range.
// Window is packed {p00,p01,p02,p10,p11,p12,p20,p21,p22}; row 0 is the oldest row.
module sobel_px
   import sobel_pkg::*;
#(
   parameter int DATA_W = PIX_W
) (
   input  logic [8:0][DATA_W-1:0] win,
   output logic [DATA_W-1:0]      mag
);
   localparam int GW = DATA_W + 3;

   function automatic logic signed [GW-1:0] ext(input logic [DATA_W-1:0] p);
      return signed'({3'b000, p});
   endfunction

   function automatic logic [GW-1:0] abs_g(input logic signed [GW-1:0] v);
      return (v < 0) ? GW'(-v) : GW'(v);
   endfunction

   function automatic logic [DATA_W-1:0] sat(input logic [GW:0] m);
      return (m > (GW+1)'(SAT_MAX)) ? DATA_W'(SAT_MAX) : m[DATA_W-1:0];
   endfunction

   logic signed [GW-1:0] p00, p01, p02, p10, p12, p20, p21, p22;
   logic signed [GW-1:0] gx, gy;
   logic [GW:0]          mag_sum;

   assign p00 = ext(win[8]);
   assign p01 = ext(win[7]);
   assign p02 = ext(win[6]);
   assign p10 = ext(win[5]);
   assign p12 = ext(win[3]);
   assign p20 = ext(win[2]);
   assign p21 = ext(win[1]);
   assign p22 = ext(win[0]);

   // Both gradients stay within +/-1020, so GW bits never overflow
   assign gx = (p02 + (p12 <<< 1) + p22) - (p00 + (p10 <<< 1) + p20);
   assign gy = (p20 + (p21 <<< 1) + p22) - (p00 + (p01 <<< 1) + p02);

   assign mag_sum = {1'b0, abs_g(gx)} + {1'b0, abs_g(gy)};
   assign mag     = sat(mag_sum);
endmodule

// File: rtl/sobel.sv
// Row-streaming 3x3 Sobel: each accepted row emits the magnitude row for the
// previously accepted (centre) row, using a two-row line buffer.
module sobel
   import sobel_pkg::*;
(
   input  logic             CLK,
   input  logic             RST,
   input  logic             SET,
   input  logic [ROW_W-1:0] row_in,
   output logic [ROW_W-1:0] row_out
);
   logic [ROW_W-1:0] top;
   logic [ROW_W-1:0] mid;
   logic [ROW_W-1:0] mag_row;

   // Columns outside the row read as zero
   function automatic logic [PIX_W-1:0] pick(input logic [ROW_W-1:0] row,
                                             input int j, input int c);
      if (j < 0 || j >= COLS) return '0;
      return row[bit_ofs(j, c) -: PIX_W];
   endfunction

   for (genvar j = 0; j < COLS; j++) begin : g_col
      for (genvar c = 0; c < CH; c++) begin : g_ch
         logic [8:0][PIX_W-1:0] win;

         assign win = {pick(top,    j-1, c), pick(top,    j, c), pick(top,    j+1, c),
                       pick(mid,    j-1, c), pick(mid,    j, c), pick(mid,    j+1, c),
                       pick(row_in, j-1, c), pick(row_in, j, c), pick(row_in, j+1, c)};

         sobel_px #(.DATA_W(PIX_W)) u_px (
            .win (win),
            .mag (mag_row[bit_ofs(j, c) -: PIX_W])
         );
      end
   end

   // Line buffer and output register advance together on each accepted row
   always_ff @(posedge CLK) begin
      if (!RST) begin
         top     <= '0;
         mid     <= '0;
         row_out <= '0;
      end else if (SET) begin
         row_out <= mag_row;
         top     <= mid;
         mid     <= row_in;
      end
   end
endmodule

// File: tb/tb_sobel.sv
// Directed bench for the Sobel row filter: reset, flat, edge, hold, saturation, stream.
module tb_sobel;
   import sobel_pkg::*;

   logic             CLK = 1'b0;
   logic             RST;
   logic             SET;
   logic [ROW_W-1:0] row_in;
   logic [ROW_W-1:0] row_out;

   int total = 0;
   int bad   = 0;

   logic [ROW_W-1:0] rows [COLS];

   sobel dut (
      .CLK     (CLK),
      .RST     (RST),
      .SET     (SET),
      .row_in  (row_in),
      .row_out (row_out)
   );

   always #5 CLK = ~CLK;

   function automatic logic [ROW_W-1:0] uni_row(input logic [23:0] pix);
      logic [ROW_W-1:0] o;
      for (int j = 0; j < COLS; j++) o[ROW_W-1-24*j -: 24] = pix;
      return o;
   endfunction

   function automatic logic [23:0] pix24(input logic [ROW_W-1:0] r, input int j);
      return r[ROW_W-1-24*j -: 24];
   endfunction

   function automatic int first_diff(input logic [ROW_W-1:0] a, input logic [ROW_W-1:0] b);
      for (int j = 0; j < COLS; j++) if (pix24(a, j) !== pix24(b, j)) return j;
      return 0;
   endfunction

   function automatic int gp(input logic [ROW_W-1:0] r, input int j, input int c);
      if (j < 0 || j >= COLS) return 0;
      return int'(r[ROW_W-1-24*j-8*c -: 8]);
   endfunction

   function automatic logic [ROW_W-1:0] ref_row(input logic [ROW_W-1:0] t,
                                                input logic [ROW_W-1:0] m,
                                                input logic [ROW_W-1:0] b);
      logic [ROW_W-1:0] o;
      int gx, gy, s;
      for (int j = 0; j < COLS; j++) begin
         for (int c = 0; c < 3; c++) begin
            gx = (gp(t, j+1, c) + 2*gp(m, j+1, c) + gp(b, j+1, c))
               - (gp(t, j-1, c) + 2*gp(m, j-1, c) + gp(b, j-1, c));
            gy = (gp(b, j-1, c) + 2*gp(b, j, c) + gp(b, j+1, c))
               - (gp(t, j-1, c) + 2*gp(t, j, c) + gp(t, j+1, c));
            s = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
            if (s > 255) s = 255;
            o[ROW_W-1-24*j-8*c -: 8] = 8'(s);
         end
      end
      return o;
   endfunction

   function automatic logic [ROW_W-1:0] gen_row(input int r);
      logic [ROW_W-1:0] o;
      for (int j = 0; j < COLS; j++)
         for (int c = 0; c < 3; c++)
            o[ROW_W-1-24*j-8*c -: 8] = 8'((r*5 + j + c*40) % 256);
      return o;
   endfunction

   task automatic set_row(input logic [ROW_W-1:0] r);
      @(negedge CLK);
      SET    = 1'b1;
      row_in = r;
      @(posedge CLK);
      #1;
      SET = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST = 1'b0;
      SET = 1'b0;
      @(posedge CLK);
      #1;
      RST = 1'b1;
   endtask

   task automatic test_reset();
      logic [ROW_W-1:0] exp;
      int j;
      set_row(uni_row(24'hFFFFFF));
      set_row(uni_row(24'h123456));
      // reset edge with SET=1 must clear everything and not load row_in
      @(negedge CLK);
      RST    = 1'b0;
      SET    = 1'b1;
      row_in = uni_row(24'hFFFFFF);
      @(posedge CLK);
      #1;
      RST = 1'b1;
      SET = 1'b0;
      exp = '0;
      total++;
      if (row_out !== exp) begin
         bad++; j = first_diff(row_out, exp);
         $display("FAIL reset_out pix=%0d got=%h want=%h", j, pix24(row_out, j), pix24(exp, j));
      end
      set_row('0);
      total++;
      if (row_out !== exp) begin
         bad++; j = first_diff(row_out, exp);
         $display("FAIL reset_buffers pix=%0d got=%h want=%h", j, pix24(row_out, j), pix24(exp, j));
      end
   endtask

   task automatic test_flat();
      logic [ROW_W-1:0] exp_sat, exp3;
      int j;
      exp_sat = uni_row(24'hFFFFFF);
      exp3    = '0;
      exp3[ROW_W-1 -: 24] = 24'hFFFFFF;
      exp3[23:0]          = 24'hFFFFFF;
      do_reset();
      set_row(uni_row(24'h808080));
      total++;
      if (row_out !== exp_sat) begin
         bad++; j = first_diff(row_out, exp_sat);
         $display("FAIL flat_out1 pix=%0d got=%h want=%h", j, pix24(row_out, j), pix24(exp_sat, j));
      end
      set_row(uni_row(24'h808080));
      total++;
      if (row_out !== exp_sat) begin
         bad++; j = first_diff(row_out, exp_sat);
         $display("FAIL flat_out2 pix=%0d got=%h want=%h", j, pix24(row_out, j), pix24(exp_sat, j));
      end
      set_row(uni_row(24'h808080));
      total++;
      if (row_out !== exp3) begin
         bad++; j = first_diff(row_out, exp3);
         $display("FAIL flat_out3 pix=%0d got=%h want=%h", j, pix24(row_out, j), pix24(exp3, j));
      end
   endtask

   task automatic test_vertical_edge();
      logic [ROW_W-1:0] r, exp;
      int j;
      r = '0;
      for (int k = 128; k < COLS; k++) r[ROW_W-1-24*k -: 24] = 24'h0A0000;
      exp = '0;
      exp[ROW_W-1-24*127 -: 24] = 24'h280000;
      exp[ROW_W-1-24*128 -: 24] = 24'h280000;
      exp[ROW_W-1-24*255 -: 24] = 24'h280000;
      do_reset();
      set_row(r);
      set_row(r);
      set_row(r);
      total++;
      if (row_out !== exp) begin
         bad++; j = first_diff(row_out, exp);
         $display("FAIL vedge_row pix=%0d got=%h want=%h", j, pix24(row_out, j), pix24(exp, j));
      end
      total++;
      if (row_out[ROW_W-1-24*127 -: 8] !== 8'd40)
         begin bad++; $display("FAIL vedge_r127 got=%0d want=40", row_out[ROW_W-1-24*127 -: 8]); end
      total++;
      if (row_out[ROW_W-1-24*128-8 -: 16] !== 16'h0000)
         begin bad++; $display("FAIL vedge_gb128 got=%h want=0000", row_out[ROW_W-1-24*128-8 -: 16]); end
   endtask

   task automatic test_hold();
      logic [ROW_W-1:0] exp_sat, exp3;
      int j;
      exp_sat = uni_row(24'hFFFFFF);
      exp3    = '0;
      exp3[ROW_W-1 -: 24] = 24'hFFFFFF;
      exp3[23:0]          = 24'hFFFFFF;
      do_reset();
      set_row(uni_row(24'h808080));
      set_row(uni_row(24'h808080));
      for (int k = 0; k < 5; k++) begin
         @(negedge CLK);
         SET    = 1'b0;
         row_in = uni_row(24'($urandom));
         @(posedge CLK);
         #1;
         total++;
         if (row_out !== exp_sat) begin
            bad++; j = first_diff(row_out, exp_sat);
            $display("FAIL hold_cyc%0d pix=%0d got=%h want=%h", k, j, pix24(row_out, j), pix24(exp_sat, j));
         end
      end
      set_row(uni_row(24'h808080));
      total++;
      if (row_out !== exp3) begin
         bad++; j = first_diff(row_out, exp3);
         $display("FAIL hold_resume pix=%0d got=%h want=%h", j, pix24(row_out, j), pix24(exp3, j));
      end
   endtask

   task automatic test_saturation();
      logic [ROW_W-1:0] exp;
      int j;
      exp = uni_row(24'hFFFFFF);
      do_reset();
      set_row(uni_row(24'hFFFFFF));
      set_row('0);
      set_row('0);
      total++;
      if (row_out !== exp) begin
         bad++; j = first_diff(row_out, exp);
         $display("FAIL sat_top pix=%0d got=%h want=%h", j, pix24(row_out, j), pix24(exp, j));
      end
      do_reset();
      set_row('0);
      set_row('0);
      set_row(uni_row(24'hFFFFFF));
      total++;
      if (row_out !== exp) begin
         bad++; j = first_diff(row_out, exp);
         $display("FAIL sat_bottom pix=%0d got=%h want=%h", j, pix24(row_out, j), pix24(exp, j));
      end
   endtask

   task automatic test_stream();
      logic [ROW_W-1:0] exp, t, m;
      int j;
      for (int k = 0; k < COLS; k++) rows[k] = gen_row(k);
      do_reset();
      for (int k = 0; k <= COLS; k++) begin
         t = (k >= 2) ? rows[k-2] : '0;
         m = (k >= 1) ? rows[k-1] : '0;
         set_row((k < COLS) ? rows[k] : '0);
         exp = ref_row(t, m, (k < COLS) ? rows[k] : '0);
         total++;
         if (row_out !== exp) begin
            bad++; j = first_diff(row_out, exp);
            $display("FAIL stream_row%0d pix=%0d got=%h want=%h", k - 1, j, pix24(row_out, j), pix24(exp, j));
         end
         // centre row 2, pixel 100: |Gx|=8, |Gy|=40 on each channel
         if (k == 3) begin
            total++;
            if (pix24(row_out, 100) !== 24'h303030)
               begin bad++; $display("FAIL stream_spot got=%h want=303030", pix24(row_out, 100)); end
         end
      end
   endtask

   initial begin
      RST    = 1'b0;
      SET    = 1'b0;
      row_in = '0;
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b1;
      test_reset();
      test_flat();
      test_vertical_edge();
      test_hold();
      test_saturation();
      test_stream();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
